// File: rtl/eda_regional_max_engine.sv
// Regional-maxima engine: local image store plus breadth-first plateau flood fill.
// Optional region counter output enabled by defining EDA_RMAX_REGION_CNT_EN.
module eda_regional_max_engine #(
  parameter int unsigned M            = 8,
  parameter int unsigned N            = 8,
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH   = $clog2(M*N),
  parameter int unsigned CONNECTIVITY = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   write_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   matrix_output,
  output logic                   busy,
  output logic                   done
`ifdef EDA_RMAX_REGION_CNT_EN
  ,
  output logic [ADDR_WIDTH:0]    region_count
`endif
);

  localparam int unsigned MN    = M * N;
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned K     = (CONNECTIVITY == 4) ? 4 : 8;
  localparam logic [PTR_W-1:0] MN_P = PTR_W'(MN);

  generate
    if (CONNECTIVITY != 4 && CONNECTIVITY != 8) begin : g_bad_conn
      $fatal(1, "eda_regional_max_engine: CONNECTIVITY must be 4 or 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SEED, S_POP, S_NEIGH, S_MARK, S_NEXT, S_FIN
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       scan_q, scan_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [ADDR_WIDTH-1:0]  cur_q, cur_d;
  logic [2:0]             k_q, k_d;
  logic                   is_max_q, is_max_d;
  logic [PIXEL_WIDTH-1:0] ref_pix_q, ref_pix_d;
  logic                   matrix_output_q, matrix_output_d;

  logic [PIXEL_WIDTH-1:0] img_q   [MN];
  logic [ADDR_WIDTH-1:0]  queue_q [MN];
  logic [MN-1:0]          visited_q;
  logic [MN-1:0]          result_q;

  logic                   img_we;
  logic                   vis_clr, vis_set, res_clr, res_set, q_we;
  logic [ADDR_WIDTH-1:0]  vis_idx, res_idx, q_idx, q_data;

  logic [ADDR_WIDTH-1:0]  scan_idx, head_idx, tail_idx;
  logic [2:0]             dir;
  int                     cur_row, cur_col, nr, nc, dr, dc;
  logic                   nb_in;
  logic [ADDR_WIDTH-1:0]  nb_addr;

`ifdef EDA_RMAX_REGION_CNT_EN
  logic [ADDR_WIDTH:0]    region_cnt_q, region_cnt_d;
  assign region_count = region_cnt_q;
`endif

  assign scan_idx      = scan_q[ADDR_WIDTH-1:0];
  assign head_idx      = head_q[ADDR_WIDTH-1:0];
  assign tail_idx      = tail_q[ADDR_WIDTH-1:0];
  assign busy          = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done          = (state_q == S_FIN);
  assign matrix_output = matrix_output_q;

  // Neighbour k maps onto the 8-way direction order UL,U,UR,L,R,DL,D,DR;
  // 4-connectivity walks only U, L, R, D of that order.
  always_comb begin
    dir = k_q;
    if (K == 4) begin
      case (k_q)
        3'd0:    dir = 3'd1;
        3'd1:    dir = 3'd3;
        3'd2:    dir = 3'd4;
        default: dir = 3'd6;
      endcase
    end
    dr = (dir < 3'd3) ? -1 : ((dir > 3'd4) ? 1 : 0);
    dc = (dir == 3'd0 || dir == 3'd3 || dir == 3'd5) ? -1 :
         ((dir == 3'd2 || dir == 3'd4 || dir == 3'd7) ? 1 : 0);
    cur_row = int'(cur_q) / int'(N);
    cur_col = int'(cur_q) % int'(N);
    nr      = cur_row + dr;
    nc      = cur_col + dc;
    nb_in   = (nr >= 0) && (nr < int'(M)) && (nc >= 0) && (nc < int'(N));
    nb_addr = ADDR_WIDTH'(nr * int'(N) + nc);
  end

  always_comb begin
    state_d         = state_q;
    scan_d          = scan_q;
    head_d          = head_q;
    tail_d          = tail_q;
    cur_d           = cur_q;
    k_d             = k_q;
    is_max_d        = is_max_q;
    ref_pix_d       = ref_pix_q;
    img_we          = write_en && !busy && ({1'b0, wr_addr} < MN_P);
    vis_clr         = 1'b0;
    vis_set         = 1'b0;
    vis_idx         = '0;
    res_clr         = 1'b0;
    res_set         = 1'b0;
    res_idx         = '0;
    q_we            = 1'b0;
    q_idx           = '0;
    q_data          = '0;
    matrix_output_d = ({1'b0, rd_addr} < MN_P) ? result_q[rd_addr] : 1'b0;
`ifdef EDA_RMAX_REGION_CNT_EN
    region_cnt_d    = region_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          vis_clr = 1'b1;
          res_clr = 1'b1;
          scan_d  = '0;
          state_d = S_SCAN;
`ifdef EDA_RMAX_REGION_CNT_EN
          region_cnt_d = '0;
`endif
        end
      end
      S_SCAN: begin
        if (scan_q == MN_P)            state_d = S_FIN;
        else if (!visited_q[scan_idx]) state_d = S_SEED;
        else                           scan_d  = scan_q + PTR_W'(1);
      end
      S_SEED: begin
        vis_set   = 1'b1;
        vis_idx   = scan_idx;
        q_we      = 1'b1;
        q_idx     = '0;
        q_data    = scan_idx;
        head_d    = '0;
        tail_d    = PTR_W'(1);
        is_max_d  = 1'b1;
        ref_pix_d = img_q[scan_idx];
        state_d   = S_POP;
      end
      S_POP: begin
        if (head_q == tail_q) begin
          if (is_max_q) begin
            head_d  = '0;
            state_d = S_MARK;
`ifdef EDA_RMAX_REGION_CNT_EN
            region_cnt_d = region_cnt_q + 1'b1;
`endif
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          cur_d   = queue_q[head_idx];
          head_d  = head_q + PTR_W'(1);
          k_d     = '0;
          state_d = S_NEIGH;
        end
      end
      S_NEIGH: begin
        if (nb_in) begin
          if (img_q[nb_addr] > ref_pix_q) begin
            is_max_d = 1'b0;
          end else if (img_q[nb_addr] == ref_pix_q && !visited_q[nb_addr]) begin
            vis_set = 1'b1;
            vis_idx = nb_addr;
            q_we    = 1'b1;
            q_idx   = tail_idx;
            q_data  = nb_addr;
            tail_d  = tail_q + PTR_W'(1);
          end
        end
        if (k_q == 3'(K - 1)) state_d = S_POP;
        else                  k_d     = k_q + 3'd1;
      end
      S_MARK: begin
        // head is reused as the mark index over queue[0..tail-1]
        res_set = 1'b1;
        res_idx = queue_q[head_idx];
        head_d  = head_q + PTR_W'(1);
        if (head_q + PTR_W'(1) == tail_q) state_d = S_NEXT;
      end
      S_NEXT: begin
        head_d  = '0;
        tail_d  = '0;
        scan_d  = scan_q + PTR_W'(1);
        state_d = S_SCAN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      scan_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      cur_q           <= '0;
      k_q             <= '0;
      is_max_q        <= 1'b0;
      ref_pix_q       <= '0;
      matrix_output_q <= 1'b0;
      visited_q       <= '0;
      result_q        <= '0;
      for (int unsigned i = 0; i < MN; i++) begin
        img_q[i]   <= '0;
        queue_q[i] <= '0;
      end
`ifdef EDA_RMAX_REGION_CNT_EN
      region_cnt_q    <= '0;
`endif
    end else begin
      state_q         <= state_d;
      scan_q          <= scan_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      cur_q           <= cur_d;
      k_q             <= k_d;
      is_max_q        <= is_max_d;
      ref_pix_q       <= ref_pix_d;
      matrix_output_q <= matrix_output_d;
      if (img_we)       img_q[wr_addr]     <= pixel_in;
      if (q_we)         queue_q[q_idx]     <= q_data;
      if (vis_clr)      visited_q          <= '0;
      else if (vis_set) visited_q[vis_idx] <= 1'b1;
      if (res_clr)      result_q           <= '0;
      else if (res_set) result_q[res_idx]  <= 1'b1;
`ifdef EDA_RMAX_REGION_CNT_EN
      region_cnt_q    <= region_cnt_d;
`endif
    end
  end

endmodule
